// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM state encoding,
// column drive patterns and small index helpers.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Active-low, one-hot-low column drive patterns.
  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Index of the lowest row that is pulled low; row 0 wins on ties.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Column index of a one-hot-low drive pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      COL1:    idx = 2'd1;
      COL2:    idx = 2'd2;
      COL3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next column in the scan order 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] col_next(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side and key-event signals of the scanner, bundled as one port.
// master: the scanner (drives columns and key outputs, reads rows).
// slave : the keypad matrix / consumer side.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0]       row;
  logic [3:0]       col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held
  );

endinterface

// File: rtl/keypad_sync.sv
// 4-bit two-flop synchronizer for the asynchronous keypad row lines.
// Resets to the idle (all rows high) pattern so no phantom press is seen.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two-stage capture of the raw rows into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value;
      // blocking here would collapse the chain into a single flop.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// synchronized rows and emits key_code with a one-cycle key_valid per press.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat of key_valid
// while a key stays held (first after REPEAT_DLY, then every REPEAT_PER).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000,
  parameter logic [26:0] REPEAT_DLY   = 27'd50000000,
  parameter logic [26:0] REPEAT_PER   = 27'd10000000
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  state_e           state_q;
  logic [15:0]      slot_q;
  logic [19:0]      deb_q;
  logic [3:0]       pat_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       col_q;
  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic [3:0]       row_s;
  logic             slot_last;
  logic             deb_last;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.row),
    .q_o (row_s)
  );

  assign slot_last = (slot_q == SCAN_DIV - 16'd1);
  assign deb_last  = (deb_q == DEBOUNCE_CNT - 20'd1);

`ifdef KEYPAD_REPEAT_EN
  logic [26:0] rep_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DLY, REPEAT_PER};
`endif

  // Scan/debounce FSM with its counters and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      slot_q      <= '0;
      deb_q       <= '0;
      pat_q       <= ROWS_IDLE;
      row_idx_q   <= '0;
      col_q       <= COL0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      // NOTE: defaults first, later assignments in this block override them,
      // which keeps key_valid a single-cycle pulse without extra logic.
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
      case (state_q)
        SCAN: begin
          if (slot_last) begin
            slot_q <= '0;
            if (row_s == ROWS_IDLE) begin
              col_q <= col_next(col_q);
            end else begin
              pat_q     <= row_s;
              row_idx_q <= lowest_low(row_s);
              deb_q     <= '0;
              state_q   <= DEBOUNCE;
            end
          end else begin
            slot_q <= slot_q + 16'd1;
          end
        end

        DEBOUNCE: begin
          if (row_s != pat_q) begin
            // Bounce: resume scanning from the frozen column.
            slot_q  <= '0;
            state_q <= SCAN;
          end else if (deb_last) begin
            key_code_q  <= {row_idx_q, col_index(col_q)};
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state_q     <= PRESSED;
          end else begin
            deb_q <= deb_q + 20'd1;
          end
        end

        PRESSED: begin
          if (row_s == ROWS_IDLE) begin
            deb_q   <= '0;
            state_q <= RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_q == REPEAT_DLY - 27'd1) begin
            // Rewind so the next hit comes REPEAT_PER cycles later.
            key_valid_q <= 1'b1;
            rep_q       <= REPEAT_DLY - REPEAT_PER;
          end else begin
            rep_q <= rep_q + 27'd1;
          end
`endif
        end

        RELEASE: begin
          if (row_s != ROWS_IDLE) begin
            deb_q   <= '0;
            state_q <= PRESSED;
          end else if (deb_last) begin
            key_held_q <= 1'b0;
            col_q      <= col_next(col_q);
            slot_q     <= '0;
            state_q    <= SCAN;
          end else begin
            deb_q <= deb_q + 20'd1;
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
